axi_ar_rr_arbiter: RTL and testbench

- Round-robin arbiter for the shared AXI read-address channel between master 0 (CPU instruction port) and master 1 (CPU data port).
- Presents one granted AR stream, with an extended slave-side ID, to the address decoder.
- Holds each grant until the AR handshake completes.
- Tracks outstanding read bursts and throttles new grants until R-channel RLAST retires them.

---
 rtl/axi_pkg.sv | 40 ++++
 rtl/axi_ar_rr_arbiter_chk.sv | 25 ++
 rtl/rd_outstanding_cnt.sv | 67 ++++++
 rtl/axi_ar_rr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_ar_rr_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-address definitions for the AR arbiter slice.
// Provides bus widths, master tags, the AR payload struct, the arbiter
// state encoding and a helper that builds the extended slave-side ID.
package axi_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_TAG_BITS   = 4;
    localparam int AXI_IDS_BITS   = AXI_TAG_BITS + AXI_ID_BITS;

    // Master tags prepended to ARID so the R channel can be routed back.
    localparam logic [AXI_TAG_BITS-1:0] TAG_M0 = 4'b0001;
    localparam logic [AXI_TAG_BITS-1:0] TAG_M1 = 4'b0010;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]    id;
        logic [AXI_ADDR_BITS-1:0]  addr;
        logic [AXI_LEN_BITS-1:0]   len;
        logic [AXI_SIZE_BITS-1:0]  size;
        logic [AXI_BURST_BITS-1:0] burst;
    } ar_payload_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_M0 = 2'b01,
        GNT_M1 = 2'b10
    } arb_state_e;

    // Extended slave-side ID: {master tag, master ARID}.
    function automatic logic [AXI_IDS_BITS-1:0] build_ids(
        input logic [AXI_TAG_BITS-1:0] tag,
        input logic [AXI_ID_BITS-1:0]  id
    );
        return {tag, id};
    endfunction

endpackage

// File: rtl/axi_ar_rr_arbiter_chk.sv
// Property checker for the AR arbiter: outstanding count bound and
// mutually exclusive ARREADY to the two masters.
// Ports: clk, rst, out_cnt (outstanding count), arready_m0/arready_m1.
module axi_ar_rr_arbiter_chk
    #(
        parameter int MAX_OUT = 4,
        parameter int CNT_W   = $clog2(MAX_OUT + 1)
    )
    (
        input logic             clk,
        input logic             rst,
        input logic [CNT_W-1:0] out_cnt,
        input logic             arready_m0,
        input logic             arready_m1
    );

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (out_cnt <= MAX_CNT));

    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(arready_m0 && arready_m1));

endmodule

// File: rtl/rd_outstanding_cnt.sv
// Saturating up/down counter of in-flight read bursts.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   inc        - one AR accepted this cycle
//   dec        - one burst retired (RLAST handshake) this cycle
//   count      - current outstanding count
//   limit_o    - registered flag, count == MAX_OUT
//   nonzero_o  - registered flag, count != 0
// An increment at MAX_OUT or a decrement at zero is dropped; when both
// legal events coincide the count is unchanged.
module rd_outstanding_cnt
    #(
        parameter int MAX_OUT = 4,
        parameter int CNT_W   = $clog2(MAX_OUT + 1)
    )
    (
        input  logic             clk,
        input  logic             rst,
        input  logic             inc,
        input  logic             dec,
        output logic [CNT_W-1:0] count,
        output logic             limit_o,
        output logic             nonzero_o
    );

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             inc_ok_s;
    logic             dec_ok_s;
    logic             limit_r;
    logic             nonzero_r;

    // Next-count computation with saturation at both ends.
    always_comb begin
        inc_ok_s   = inc && (cnt_r != MAX_CNT);
        dec_ok_s   = dec && (cnt_r != ZERO_CNT);
        cnt_next_s = cnt_r;
        case ({inc_ok_s, dec_ok_s})
            2'b10:   cnt_next_s = cnt_r + ONE_CNT;
            2'b01:   cnt_next_s = cnt_r - ONE_CNT;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Count register plus status flags registered from the next value so
    // they line up with the count itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= ZERO_CNT;
            limit_r   <= 1'b0;
            nonzero_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            limit_r   <= (cnt_next_s == MAX_CNT);
            nonzero_r <= (cnt_next_s != ZERO_CNT);
        end
    end

    assign count     = cnt_r;
    assign limit_o   = limit_r;
    assign nonzero_o = nonzero_r;

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin arbiter for the shared AXI AR channel between master 0
// (instruction port) and master 1 (data port).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   AR*_M0 / AR*_M1               - AR channels from the two masters
//   ARREADY_M0 / ARREADY_M1       - accept back to the masters
//   IDS_M, ADDR_M, LEN_M, SIZE_M,
//   BURST_M, VALID_M              - granted AR stream to the decoder
//   READY_S                       - selected slave ARREADY
//   RVALID_S, RREADY_S, RLAST_S   - R handshake used to retire bursts
//   busy_o                        - outstanding bursts exist
// Arbitration is registered: a request is seen in IDLE, the grant state is
// entered next cycle and held until the AR handshake or until the master
// withdraws ARVALID. New grants stall while MAX_OUT bursts are in flight.
module axi_ar_rr_arbiter
    import axi_pkg::*;
    #(
        parameter int MAX_OUT = 4,
        parameter int CNT_W   = $clog2(MAX_OUT + 1)
    )
    (
        input  logic                      clk,
        input  logic                      rst,
        input  logic [AXI_ID_BITS-1:0]    ARID_M0,
        input  logic [AXI_ADDR_BITS-1:0]  ARADDR_M0,
        input  logic [AXI_LEN_BITS-1:0]   ARLEN_M0,
        input  logic [AXI_SIZE_BITS-1:0]  ARSIZE_M0,
        input  logic [AXI_BURST_BITS-1:0] ARBURST_M0,
        input  logic                      ARVALID_M0,
        output logic                      ARREADY_M0,
        input  logic [AXI_ID_BITS-1:0]    ARID_M1,
        input  logic [AXI_ADDR_BITS-1:0]  ARADDR_M1,
        input  logic [AXI_LEN_BITS-1:0]   ARLEN_M1,
        input  logic [AXI_SIZE_BITS-1:0]  ARSIZE_M1,
        input  logic [AXI_BURST_BITS-1:0] ARBURST_M1,
        input  logic                      ARVALID_M1,
        output logic                      ARREADY_M1,
        output logic [AXI_IDS_BITS-1:0]   IDS_M,
        output logic [AXI_ADDR_BITS-1:0]  ADDR_M,
        output logic [AXI_LEN_BITS-1:0]   LEN_M,
        output logic [AXI_SIZE_BITS-1:0]  SIZE_M,
        output logic [AXI_BURST_BITS-1:0] BURST_M,
        output logic                      VALID_M,
        input  logic                      READY_S,
        input  logic                      RVALID_S,
        input  logic                      RREADY_S,
        input  logic                      RLAST_S,
        output logic                      busy_o
    );

    arb_state_e               state_r;
    arb_state_e               state_next_s;
    logic                     last_grant_r;   // 1'b0 = M0, 1'b1 = M1
    logic                     hs_s;
    logic                     retire_s;
    logic [CNT_W-1:0]         out_cnt_s;
    logic                     limit_s;
    logic                     nonzero_s;
    ar_payload_t              m0_payload_s;
    ar_payload_t              m1_payload_s;
    ar_payload_t              payload_s;
    logic [AXI_TAG_BITS-1:0]  tag_s;
    logic                     valid_s;
    logic                     arready_m0_s;
    logic                     arready_m1_s;

    assign m0_payload_s = '{id: ARID_M0, addr: ARADDR_M0, len: ARLEN_M0,
                            size: ARSIZE_M0, burst: ARBURST_M0};
    assign m1_payload_s = '{id: ARID_M1, addr: ARADDR_M1, len: ARLEN_M1,
                            size: ARSIZE_M1, burst: ARBURST_M1};

    assign retire_s = RVALID_S && RREADY_S && RLAST_S;

    // Next-state and granted-stream mux; everything is zero in IDLE.
    always_comb begin
        state_next_s = state_r;
        payload_s    = '0;
        tag_s        = 4'b0000;
        valid_s      = 1'b0;
        arready_m0_s = 1'b0;
        arready_m1_s = 1'b0;
        hs_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (!limit_s && (ARVALID_M0 || ARVALID_M1)) begin
                    if (ARVALID_M0 && ARVALID_M1) begin
                        // Tie: the master that did not win last time.
                        state_next_s = last_grant_r ? GNT_M0 : GNT_M1;
                    end else if (ARVALID_M0) begin
                        state_next_s = GNT_M0;
                    end else begin
                        state_next_s = GNT_M1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT_M0: begin
                payload_s    = m0_payload_s;
                tag_s        = TAG_M0;
                valid_s      = ARVALID_M0;
                arready_m0_s = READY_S;
                if (ARVALID_M0 && READY_S) begin
                    hs_s         = 1'b1;
                    state_next_s = IDLE;
                end else if (!ARVALID_M0) begin
                    // Master withdrew the request: drop the grant quietly.
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GNT_M0;
                end
            end
            GNT_M1: begin
                payload_s    = m1_payload_s;
                tag_s        = TAG_M1;
                valid_s      = ARVALID_M1;
                arready_m1_s = READY_S;
                if (ARVALID_M1 && READY_S) begin
                    hs_s         = 1'b1;
                    state_next_s = IDLE;
                end else if (!ARVALID_M1) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GNT_M1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; reset abandons any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Round-robin pointer, updated only on a completed AR handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (hs_s) begin
            last_grant_r <= (state_r == GNT_M1);
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    rd_outstanding_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_out_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (hs_s),
        .dec       (retire_s),
        .count     (out_cnt_s),
        .limit_o   (limit_s),
        .nonzero_o (nonzero_s)
    );

    axi_ar_rr_arbiter_chk #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .out_cnt    (out_cnt_s),
        .arready_m0 (arready_m0_s),
        .arready_m1 (arready_m1_s)
    );

    assign IDS_M      = build_ids(tag_s, payload_s.id);
    assign ADDR_M     = payload_s.addr;
    assign LEN_M      = payload_s.len;
    assign SIZE_M     = payload_s.size;
    assign BURST_M    = payload_s.burst;
    assign VALID_M    = valid_s;
    assign ARREADY_M0 = arready_m0_s;
    assign ARREADY_M1 = arready_m1_s;
    assign busy_o     = nonzero_s;

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Directed bench for axi_ar_rr_arbiter built with MAX_OUT=2.
module tb_axi_ar_rr_arbiter;
    import axi_pkg::*;

    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  IDS_M;
    logic [31:0] ADDR_M;
    logic [3:0]  LEN_M;
    logic [2:0]  SIZE_M;
    logic [1:0]  BURST_M;
    logic        VALID_M;
    logic        READY_S;
    logic        RVALID_S, RREADY_S, RLAST_S;
    logic        busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    axi_ar_rr_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
        .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .IDS_M(IDS_M), .ADDR_M(ADDR_M), .LEN_M(LEN_M), .SIZE_M(SIZE_M),
        .BURST_M(BURST_M), .VALID_M(VALID_M), .READY_S(READY_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are then changed and
    // outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rlast(input logic v);
        RVALID_S = v;
        RREADY_S = v;
        RLAST_S  = v;
    endtask

    initial begin
        rst = 1'b1;
        ARID_M0 = 4'h5; ARADDR_M0 = 32'h0001_0000; ARLEN_M0 = 4'd3;
        ARSIZE_M0 = 3'd3; ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b0;
        ARID_M1 = 4'hA; ARADDR_M1 = 32'h2000_0040; ARLEN_M1 = 4'd7;
        ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01; ARVALID_M1 = 1'b0;
        READY_S = 1'b0;
        rlast(1'b0);
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(VALID_M), 32'h0);
        check("rst_ids", 32'(IDS_M), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'({ARREADY_M0, ARREADY_M1}), 32'h0);
        check("rst_addr", ADDR_M, 32'h0);

        // Single M0 request, slave stalls two cycles
        ARVALID_M0 = 1'b1;
        #1;
        check("t1_idle_valid", 32'(VALID_M), 32'h0);
        tick();
        check("t1_valid", 32'(VALID_M), 32'h1);
        check("t1_ids", 32'(IDS_M), 32'h15);
        check("t1_addr", ADDR_M, 32'h0001_0000);
        check("t1_len", 32'(LEN_M), 32'h3);
        check("t1_rdy_low", 32'(ARREADY_M0), 32'h0);
        tick();
        check("t1_hold", 32'(VALID_M), 32'h1);
        READY_S = 1'b1;
        #1;
        check("t1_rdy_pulse", 32'({ARREADY_M0, ARREADY_M1}), 32'h2);
        tick();
        ARVALID_M0 = 1'b0;
        READY_S = 1'b0;
        #1;
        check("t1_idle", 32'(VALID_M), 32'h0);
        check("t1_addr_zero", ADDR_M, 32'h0);
        check("t1_cnt", 32'(dut.out_cnt_s), 32'h1);
        check("t1_busy", 32'(busy_o), 32'h1);
        rlast(1'b1);
        tick();
        rlast(1'b0);
        #1;
        check("t1_retired", 32'(busy_o), 32'h0);

        // Continuous tie: last winner was M0, so M1, M0, M1, M0
        ARVALID_M0 = 1'b1;
        ARVALID_M1 = 1'b1;
        READY_S = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rlast(1'b1);
            #1;
            check("t2_idle_gap", 32'(VALID_M), 32'h0);
            tick();
            rlast(1'b0);
            #1;
            if (i % 2 == 0) begin
                check("t2_ids_m1", 32'(IDS_M), 32'h2A);
                check("t2_rdy_m1", 32'({ARREADY_M0, ARREADY_M1}), 32'h1);
            end else begin
                check("t2_ids_m0", 32'(IDS_M), 32'h15);
                check("t2_rdy_m0", 32'({ARREADY_M0, ARREADY_M1}), 32'h2);
            end
            tick();
        end
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;
        READY_S = 1'b0;
        #1;
        check("t2_cnt", 32'(dut.out_cnt_s), 32'h1);

        // AR handshake coincides with RLAST at count 1
        ARVALID_M1 = 1'b1;
        tick();
        READY_S = 1'b1;
        rlast(1'b1);
        #1;
        check("t3_rdy", 32'(ARREADY_M1), 32'h1);
        tick();
        ARVALID_M1 = 1'b0;
        READY_S = 1'b0;
        rlast(1'b0);
        #1;
        check("t3_cnt", 32'(dut.out_cnt_s), 32'h1);
        check("t3_busy", 32'(busy_o), 32'h1);

        // Fill to MAX_OUT=2, third request must wait for a retirement
        ARVALID_M0 = 1'b1;
        READY_S = 1'b1;
        tick();
        check("t4_grant", 32'(ARREADY_M0), 32'h1);
        tick();
        ARADDR_M0 = 32'h0001_0100;
        #1;
        check("t4_full_cnt", 32'(dut.out_cnt_s), 32'h2);
        tick();
        check("t4_blocked", 32'(VALID_M), 32'h0);
        check("t4_blocked_rdy", 32'(ARREADY_M0), 32'h0);
        rlast(1'b1);
        tick();
        rlast(1'b0);
        #1;
        check("t4_after_rlast", 32'(VALID_M), 32'h0);
        check("t4_cnt1", 32'(dut.out_cnt_s), 32'h1);
        tick();
        check("t4_third_valid", 32'(VALID_M), 32'h1);
        check("t4_third_addr", ADDR_M, 32'h0001_0100);
        tick();
        ARVALID_M0 = 1'b0;
        READY_S = 1'b0;
        rlast(1'b1);
        tick();
        tick();
        rlast(1'b0);
        #1;
        check("t4_drain", 32'(busy_o), 32'h0);

        // Reset in the middle of a stalled M1 grant
        ARVALID_M1 = 1'b1;
        READY_S = 1'b1;
        tick();
        tick();
        READY_S = 1'b0;
        tick();
        check("t5_granted", 32'(VALID_M), 32'h1);
        check("t5_busy", 32'(busy_o), 32'h1);
        rst = 1'b1;
        tick();
        check("t5_valid", 32'(VALID_M), 32'h0);
        check("t5_rdy", 32'({ARREADY_M0, ARREADY_M1}), 32'h0);
        check("t5_cnt", 32'(dut.out_cnt_s), 32'h0);
        rst = 1'b0;
        ARVALID_M0 = 1'b1;
        tick();
        check("t5_tie_m0", 32'(IDS_M), 32'h15);
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;
        tick();

        // M1 withdraws its request while granted
        ARVALID_M1 = 1'b1;
        tick();
        check("t6_valid", 32'(VALID_M), 32'h1);
        tick();
        check("t6_state", 32'(dut.state_r), 32'(GNT_M1));
        ARVALID_M1 = 1'b0;
        #1;
        check("t6_no_rdy", 32'(ARREADY_M1), 32'h0);
        check("t6_valid_drop", 32'(VALID_M), 32'h0);
        tick();
        check("t6_idle", 32'(dut.state_r), 32'(IDLE));
        check("t6_cnt", 32'(dut.out_cnt_s), 32'h0);
        ARVALID_M0 = 1'b1;
        ARVALID_M1 = 1'b1;
        tick();
        check("t6_tie_m0", 32'(IDS_M), 32'h15);
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
